// File: rtl/iic_wr_byte.sv
`default_nettype none
// ============================================================================
// Module   : iic_wr_byte
// Purpose  : Serialises one DW-bit byte MSB-first onto SDA, then releases SDA
//            for one SCL period and samples the slave ACK bit. Used for the
//            address, command and register bytes of the SHT21 IIC controller.
//            Bit timing follows the one-cycle SCL phase strobes from the
//            shared SCL generator.
// Ports    :
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   abort    in   synchronous clear back to IDLE (beats start)
//   start    in   one-cycle request to send data_in (IDLE only)
//   data_in  in   byte to transmit, latched on accepted start
//   scl_hc   in   strobe at centre of SCL high
//   scl_ls   in   strobe at SCL falling edge
//   scl_lc   in   strobe at centre of SCL low
//   sda_in   in   SDA pad input (asynchronous)
//   sdar     out  SDA output value
//   sdalink  out  SDA output enable (1 = drive sdar)
//   busy     out  high from accepted start until done
//   done     out  one-cycle pulse at the end of the ACK bit period
//   nack     out  1 = slave NACKed the last byte; held until next start
// Revision : 1.0 - initial release
// ============================================================================
module iic_wr_byte #(
    parameter int DW          = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          abort,
    input  logic          start,
    input  logic [DW-1:0] data_in,
    input  logic          scl_hc,
    input  logic          scl_ls,
    input  logic          scl_lc,
    input  logic          sda_in,
    output logic          sdar,
    output logic          sdalink,
    output logic          busy,
    output logic          done,
    output logic          nack
);

    localparam int             c_cnt_w    = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(DW - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_LC = 2'd1,
        SHIFT   = 2'd2,
        ACK     = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // SDA input synchroniser; free-running, only rst_n touches it.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sda_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sda_in};
        end
    end

    assign w_sda_sync = r_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Registered state and outputs
    // ------------------------------------------------------------------
    state_t             r_state,     w_state;
    logic [DW-1:0]      r_shreg,     w_shreg;
    logic [c_cnt_w-1:0] r_cnt,       w_cnt;
    logic               r_high_seen, w_high_seen;
    logic               r_sdar,      w_sdar;
    logic               r_sdalink,   w_sdalink;
    logic               r_busy,      w_busy;
    logic               r_done,      w_done;
    logic               r_nack,      w_nack;
    logic [c_cnt_w-1:0] w_bit_idx;

    // Shift register is never shifted; the counter selects the bit so the
    // latched byte stays intact for the whole transfer.
    assign w_bit_idx = c_last_bit - r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_shreg     <= '0;
            r_cnt       <= '0;
            r_high_seen <= 1'b0;
            r_sdar      <= 1'b0;
            r_sdalink   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_nack      <= 1'b0;
        end else if (abort) begin
            r_state     <= IDLE;
            r_shreg     <= '0;
            r_cnt       <= '0;
            r_high_seen <= 1'b0;
            r_sdar      <= 1'b0;
            r_sdalink   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_nack      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_shreg     <= w_shreg;
            r_cnt       <= w_cnt;
            r_high_seen <= w_high_seen;
            r_sdar      <= w_sdar;
            r_sdalink   <= w_sdalink;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_nack      <= w_nack;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Strobe priority is scl_lc > scl_hc > scl_ls.
    // high_seen guarantees a falling edge only ends a bit whose high phase
    // was actually observed, so a start landing mid-period is harmless.
    // ------------------------------------------------------------------
    always_comb begin
        w_state     = r_state;
        w_shreg     = r_shreg;
        w_cnt       = r_cnt;
        w_high_seen = r_high_seen;
        w_sdar      = r_sdar;
        w_sdalink   = r_sdalink;
        w_busy      = r_busy;
        w_done      = 1'b0;
        w_nack      = r_nack;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_shreg = data_in;
                    w_cnt   = '0;
                    w_nack  = 1'b0;
                    w_busy  = 1'b1;
                    w_state = WAIT_LC;
                end
            end

            WAIT_LC: begin
                if (scl_lc) begin
                    w_sdalink = 1'b1;
                    w_sdar    = r_shreg[DW-1];
                    w_state   = SHIFT;
                end
            end

            SHIFT: begin
                if (scl_lc) begin
                    w_sdar = r_shreg[w_bit_idx];
                end else if (scl_hc) begin
                    w_high_seen = 1'b1;
                end else if (scl_ls && r_high_seen) begin
                    w_high_seen = 1'b0;
                    if (r_cnt == c_last_bit) begin
                        w_state = ACK;
                    end else begin
                        w_cnt = r_cnt + 1'b1;
                    end
                end
            end

            ACK: begin
                if (scl_lc) begin
                    w_sdalink = 1'b0;
                    w_sdar    = 1'b0;
                end else if (scl_hc && !r_sdalink) begin
                    // Sample only once SDA has been released to the slave.
                    w_nack      = w_sda_sync;
                    w_high_seen = 1'b1;
                end else if (scl_ls && r_high_seen) begin
                    w_done      = 1'b1;
                    w_busy      = 1'b0;
                    w_high_seen = 1'b0;
                    w_state     = IDLE;
                end
            end

            default: begin
                w_state = IDLE;
            end
        endcase
    end

    assign sdar    = r_sdar;
    assign sdalink = r_sdalink;
    assign busy    = r_busy;
    assign done    = r_done;
    assign nack    = r_nack;

endmodule
`default_nettype wire

// File: tb/tb_iic_wr_byte.sv
`default_nettype none
// ============================================================================
// Module   : tb_iic_wr_byte
// Purpose  : Self-checking bench for iic_wr_byte. Stimulus pushes expected
//            bits, ACK results and point-in-time output snapshots into
//            queues; a monitor compares them against the DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iic_wr_byte;

    localparam logic [1:0] K_BIT  = 2'd0;
    localparam logic [1:0] K_DONE = 2'd1;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] val;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       abort;
    logic       start;
    logic [7:0] data_in;
    logic       scl_hc;
    logic       scl_ls;
    logic       scl_lc;
    logic       sda_in;
    logic       sdar;
    logic       sdalink;
    logic       busy;
    logic       done;
    logic       nack;

    logic       slave_ack;

    exp_t       exp_q[$];
    logic [4:0] st_q[$];

    int n_pass;
    int n_total;
    int lc_cnt;
    bit final_req;
    bit final_done;

    iic_wr_byte #(
        .DW          (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .abort   (abort),
        .start   (start),
        .data_in (data_in),
        .scl_hc  (scl_hc),
        .scl_ls  (scl_ls),
        .scl_lc  (scl_lc),
        .sda_in  (sda_in),
        .sdar    (sdar),
        .sdalink (sdalink),
        .busy    (busy),
        .done    (done),
        .nack    (nack)
    );

    // Open-drain bus: master drives only when enabled; slave pulls low for
    // ACK once the master has released the line during a transfer.
    assign sda_in = (sdalink ? sdar : 1'b1) & ~(slave_ack & busy & ~sdalink);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SCL phase strobes: 16-cycle period; ls at 0, lc at 4, hc at 12.
    initial begin
        int phase;
        phase  = 15;
        scl_hc = 1'b0;
        scl_ls = 1'b0;
        scl_lc = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            phase  = (phase == 15) ? 0 : phase + 1;
            scl_ls = (phase == 0);
            scl_lc = (phase == 4);
            scl_hc = (phase == 12);
        end
    end

    task automatic check(input string name, input int act, input int req);
        n_total++;
        if (act == req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: all comparisons happen here, on the falling clock edge.
    // ------------------------------------------------------------------
    initial begin
        exp_t       e;
        logic [4:0] s;
        n_pass     = 0;
        n_total    = 0;
        lc_cnt     = 0;
        final_done = 1'b0;
        forever begin
            @(negedge clk);
            while (st_q.size() > 0) begin
                s = st_q.pop_front();
                check("state{sdar,sdalink,busy,done,nack}",
                      int'({sdar, sdalink, busy, done, nack}), int'(s));
            end
            if (rst_n) begin
                if (scl_hc && sdalink) begin
                    if (exp_q.size() == 0) begin
                        check("bit_unexpected", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.kind != K_BIT) check("bit_order", int'(K_BIT), int'(e.kind));
                        else                 check("bit", int'(sdar), int'(e.val[0]));
                    end
                end
                if (done) begin
                    if (exp_q.size() == 0) begin
                        check("done_unexpected", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.kind != K_DONE) begin
                            check("done_order", int'(K_DONE), int'(e.kind));
                        end else begin
                            check("done_nack", int'(nack), int'(e.val[0]));
                            check("done_periods", lc_cnt, 9);
                            check("done_busy", int'(busy), 0);
                        end
                    end
                end
                if (!busy)       lc_cnt = 0;
                else if (scl_lc) lc_cnt++;
            end
            if (final_req && !final_done) begin
                check("leftover_expectations", exp_q.size(), 0);
                final_done = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    // Returns 1 ns after the clock edge that consumed the requested strobe.
    task automatic wait_strobe(input int which);
        int n;
        bit hit;
        n   = 0;
        hit = 1'b0;
        while (!hit) begin
            @(posedge clk);
            hit = (which == 0) ? scl_ls : (which == 1) ? scl_lc : scl_hc;
            n++;
            if (n > 1000) begin
                $display("FAIL wait_strobe: timeout waiting strobe %0d", which);
                $fatal(1);
            end
        end
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy) begin
            @(negedge clk);
            n++;
            if (n > 2000) begin
                $display("FAIL wait_idle: busy stuck high");
                $fatal(1);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_start(input logic [7:0] d);
        start   = 1'b1;
        data_in = d;
        @(posedge clk);
        #1;
        start   = 1'b0;
    endtask

    task automatic push_bits(input logic [7:0] d, input int nbits);
        exp_t e;
        for (int i = 0; i < nbits; i++) begin
            e.kind = K_BIT;
            e.val  = {7'd0, d[7-i]};
            exp_q.push_back(e);
        end
    endtask

    task automatic push_done(input logic nk);
        exp_t e;
        e.kind = K_DONE;
        e.val  = {7'd0, nk};
        exp_q.push_back(e);
    endtask

    // Snapshot {sdar, sdalink, busy, done, nack} checked at the next negedge.
    task automatic push_state(input logic [4:0] s);
        st_q.push_back(s);
    endtask

    task automatic idle_periods(input int n);
        for (int i = 0; i < n; i++) wait_strobe(0);
    endtask

    // ------------------------------------------------------------------
    // Directed tests
    // ------------------------------------------------------------------
    initial begin
        int n;
        rst_n     = 1'b0;
        abort     = 1'b0;
        start     = 1'b0;
        data_in   = 8'h00;
        slave_ack = 1'b0;
        final_req = 1'b0;

        // 1. Reset and idle
        repeat (4) @(posedge clk);
        #1;
        push_state(5'b00000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wait_strobe(2);
            push_state(5'b00000);
        end

        // 2. 0x80 with ACK
        slave_ack = 1'b1;
        push_bits(8'h80, 8);
        push_done(1'b0);
        wait_strobe(0);
        send_start(8'h80);
        push_state(5'b00100);
        wait_idle();

        // 3. 0xE3 with NACK; nack holds afterwards
        slave_ack = 1'b0;
        push_bits(8'hE3, 8);
        push_done(1'b1);
        wait_strobe(0);
        send_start(8'hE3);
        wait_idle();
        idle_periods(3);
        push_state(5'b00001);

        // 4. Start between scl_hc and scl_ls; nack clears on accept
        slave_ack = 1'b1;
        push_bits(8'h96, 8);
        push_done(1'b0);
        wait_strobe(2);
        @(posedge clk);
        #1;
        send_start(8'h96);
        push_state(5'b00100);
        wait_idle();

        // 5. Abort during bit 4 of 0xA5, then 0x5A
        push_bits(8'hA5, 4);
        wait_strobe(0);
        send_start(8'hA5);
        for (int i = 0; i < 4; i++) wait_strobe(2);
        wait_strobe(1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        push_state(5'b00000);
        idle_periods(2);
        push_state(5'b00000);
        push_bits(8'h5A, 8);
        push_done(1'b0);
        wait_strobe(0);
        send_start(8'h5A);
        wait_idle();

        // 6. Start while busy is ignored; start+abort stays idle
        push_bits(8'h3C, 8);
        push_done(1'b0);
        wait_strobe(0);
        send_start(8'h3C);
        for (int i = 0; i < 3; i++) wait_strobe(2);
        send_start(8'hFF);
        wait_idle();
        wait_strobe(0);
        start = 1'b1;
        abort = 1'b1;
        data_in = 8'hFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        push_state(5'b00000);
        idle_periods(3);
        push_state(5'b00000);

        // Drain and summarise
        n = 0;
        while ((exp_q.size() > 0 || st_q.size() > 0) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        final_req = 1'b1;
        n = 0;
        while (!final_done && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
